// File: rtl/sga_render_pkg.sv
// Shared constants for the SGA render engine: grid geometry, cell codes,
// FSM state encodings and a small cell-code helper.
package sga_render_pkg;

  localparam int POS_W_DEF      = 8;
  localparam int SIZE_W_DEF     = 6;
  localparam int GRID_CELLS_DEF = 256;

  // Two-bit cell codes stored in the frame buffer.
  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_BODY  = 2'b01;
  localparam logic [1:0] CELL_HEAD  = 2'b10;
  localparam logic [1:0] CELL_APPLE = 2'b11;

  // Render FSM state codes; also exported on db_state.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLEAR = 3'd1;
  localparam logic [2:0] ST_READY = 3'd2;
  localparam logic [2:0] ST_FETCH = 3'd3;
  localparam logic [2:0] ST_DRAW  = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  // Code for a snake segment read from body RAM: first segment is the head.
  function automatic logic [1:0] seg_code(input logic is_head);
    return is_head ? CELL_HEAD : CELL_BODY;
  endfunction

endpackage

// File: rtl/sga_edge_detector.sv
// Rising-edge detector with a one-bit history flop. The history resets to 0,
// so an input that is already high when reset releases reads as an edge.
module sga_edge_detector (
  input  logic clock,
  input  logic restart_n,
  input  logic sig_i,
  output logic rise_o
);

  logic prev_d;
  logic prev_q;

  // The history flop simply tracks the input level.
  always_comb begin
    prev_d = sig_i;
  end

  // History flop.
  always_ff @(posedge clock or negedge restart_n) begin
    if (!restart_n) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign rise_o = sig_i & ~prev_q;

endmodule

// File: rtl/sga_render_engine.sv
// SGA render datapath. Each render_count pulse draws one item into the frame
// buffer (erase old tail, head, body segments, apple); a render_clr rising
// edge sweeps the whole grid to EMPTY. Outputs decode registered state.
module sga_render_engine
  import sga_render_pkg::*;
#(
  parameter int POS_W      = POS_W_DEF,
  parameter int GRID_CELLS = GRID_CELLS_DEF,
  parameter int SIZE_W     = SIZE_W_DEF
) (
  input  logic              clock,
  input  logic              restart_n,
  input  logic              render_clr,
  input  logic              render_count,
  input  logic              frame_rearm,
  input  logic [SIZE_W-1:0] snake_size,
  input  logic [POS_W-1:0]  apple_pos,
  output logic [SIZE_W-1:0] body_addr,
  input  logic [POS_W-1:0]  body_data,
  output logic              fb_we,
  output logic [POS_W-1:0]  fb_addr,
  output logic [1:0]        fb_data,
  output logic              render_finish,
  output logic              busy,
  output logic [2:0]        db_state
);

  localparam int IDX_W = SIZE_W + 1;
  localparam logic [POS_W-1:0] CLR_LAST = POS_W'(GRID_CELLS - 1);

  logic [2:0]        state_d, state_q;
  logic [IDX_W-1:0]  idx_d, idx_q;
  logic [SIZE_W-1:0] size_l_d, size_l_q;
  logic              tail_valid_d, tail_valid_q;
  logic [POS_W-1:0]  prev_tail_d, prev_tail_q;
  logic [POS_W-1:0]  next_tail_d, next_tail_q;
  logic [POS_W-1:0]  clr_cnt_d, clr_cnt_q;

  logic              clr_rise_s;
  logic              rearm_ok_s;
  logic [IDX_W-1:0]  last_idx_s;
  logic              is_erase_s, is_apple_s, is_head_s, is_tail_src_s;
  logic [SIZE_W-1:0] size_in_s;
  logic [SIZE_W-1:0] ram_idx_s;

  sga_edge_detector u_clr_edge (
    .clock     (clock),
    .restart_n (restart_n),
    .sig_i     (render_clr),
    .rise_o    (clr_rise_s)
  );

  // Item decode: idx 0 erases the old tail, idx size_l+1 is the apple.
  assign last_idx_s    = {1'b0, size_l_q} + {{SIZE_W{1'b0}}, 1'b1};
  assign is_erase_s    = (idx_q == {IDX_W{1'b0}});
  assign is_apple_s    = (idx_q == last_idx_s);
  assign is_head_s     = (idx_q == {{SIZE_W{1'b0}}, 1'b1});
  assign is_tail_src_s = (idx_q == {1'b0, size_l_q});
  assign ram_idx_s     = idx_q[SIZE_W-1:0] - {{(SIZE_W-1){1'b0}}, 1'b1};
  assign size_in_s     = (snake_size == {SIZE_W{1'b0}}) ? {{(SIZE_W-1){1'b0}}, 1'b1} : snake_size;
  assign rearm_ok_s    = (state_q == ST_READY) || (state_q == ST_FETCH) ||
                         (state_q == ST_DRAW)  || (state_q == ST_DONE);

  // Next-state logic: clear edge beats rearm, rearm beats render_count.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    size_l_d     = size_l_q;
    tail_valid_d = tail_valid_q;
    prev_tail_d  = prev_tail_q;
    next_tail_d  = next_tail_q;
    clr_cnt_d    = clr_cnt_q;
    if (clr_rise_s) begin
      state_d      = ST_CLEAR;
      clr_cnt_d    = {POS_W{1'b0}};
      tail_valid_d = 1'b0;
    end else if (frame_rearm && rearm_ok_s) begin
      state_d = ST_READY;
      idx_d   = {IDX_W{1'b0}};
    end else begin
      case (state_q)
        ST_CLEAR: begin
          clr_cnt_d = clr_cnt_q + {{(POS_W-1){1'b0}}, 1'b1};
          if (clr_cnt_q == CLR_LAST) begin
            state_d = ST_READY;
            idx_d   = {IDX_W{1'b0}};
          end else begin
            state_d = ST_CLEAR;
          end
        end
        ST_READY: begin
          if (render_count) begin
            state_d = ST_FETCH;
            // Snake length is frozen for the whole pass at its first item.
            if (is_erase_s) begin
              size_l_d = size_in_s;
            end else begin
              size_l_d = size_l_q;
            end
          end else begin
            state_d = ST_READY;
          end
        end
        ST_FETCH: begin
          state_d = ST_DRAW;
        end
        ST_DRAW: begin
          idx_d = idx_q + {{SIZE_W{1'b0}}, 1'b1};
          // The last body segment becomes the tail to erase on the next pass.
          if (is_tail_src_s) begin
            next_tail_d = body_data;
          end else begin
            next_tail_d = next_tail_q;
          end
          if (is_apple_s) begin
            state_d      = ST_DONE;
            prev_tail_d  = next_tail_q;
            tail_valid_d = 1'b1;
          end else if (render_count) begin
            state_d = ST_FETCH;
          end else begin
            state_d = ST_READY;
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and counter registers.
  always_ff @(posedge clock or negedge restart_n) begin
    if (!restart_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= {IDX_W{1'b0}};
      size_l_q     <= {SIZE_W{1'b0}};
      tail_valid_q <= 1'b0;
      prev_tail_q  <= {POS_W{1'b0}};
      next_tail_q  <= {POS_W{1'b0}};
      clr_cnt_q    <= {POS_W{1'b0}};
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      size_l_q     <= size_l_d;
      tail_valid_q <= tail_valid_d;
      prev_tail_q  <= prev_tail_d;
      next_tail_q  <= next_tail_d;
      clr_cnt_q    <= clr_cnt_d;
    end
  end

  // Output decode: frame buffer port is active only in CLEAR and DRAW.
  always_comb begin
    fb_we     = 1'b0;
    fb_addr   = {POS_W{1'b0}};
    fb_data   = CELL_EMPTY;
    body_addr = {SIZE_W{1'b0}};
    case (state_q)
      ST_CLEAR: begin
        fb_we   = 1'b1;
        fb_addr = clr_cnt_q;
        fb_data = CELL_EMPTY;
      end
      ST_FETCH: begin
        if (!is_erase_s && !is_apple_s) begin
          body_addr = ram_idx_s;
        end else begin
          body_addr = {SIZE_W{1'b0}};
        end
      end
      ST_DRAW: begin
        if (is_erase_s) begin
          fb_we   = tail_valid_q;
          fb_addr = tail_valid_q ? prev_tail_q : {POS_W{1'b0}};
          fb_data = CELL_EMPTY;
        end else if (is_apple_s) begin
          fb_we   = 1'b1;
          fb_addr = apple_pos;
          fb_data = CELL_APPLE;
        end else begin
          fb_we   = 1'b1;
          fb_addr = body_data;
          fb_data = seg_code(is_head_s);
        end
      end
      default: begin
        fb_we = 1'b0;
      end
    endcase
  end

  assign busy          = (state_q == ST_CLEAR) || (state_q == ST_FETCH) || (state_q == ST_DRAW);
  assign render_finish = (state_q == ST_DONE);
  assign db_state      = state_q;

endmodule

// File: tb/tb_sga_render_engine.sv
// Self-checking bench for sga_render_engine. A game-level model predicts the
// ordered frame-buffer writes of each pass and the resulting frame image; one
// monitor compares every DUT write against it, and directed literals pin the
// model on the key scenarios.
module tb_sga_render_engine;

  localparam logic [1:0] E = 2'b00;
  localparam logic [1:0] B = 2'b01;
  localparam logic [1:0] H = 2'b10;
  localparam logic [1:0] A = 2'b11;

  typedef struct packed {
    logic [7:0] a;
    logic [1:0] d;
  } wr_t;

  logic       clock = 1'b0;
  logic       restart_n, render_clr, render_count, frame_rearm;
  logic [5:0] snake_size;
  logic [7:0] apple_pos;
  logic [5:0] body_addr;
  logic [7:0] body_data = 8'h00;
  logic       fb_we;
  logic [7:0] fb_addr;
  logic [1:0] fb_data;
  logic       render_finish, busy;
  logic [2:0] db_state;

  sga_render_engine dut (
    .clock(clock), .restart_n(restart_n), .render_clr(render_clr),
    .render_count(render_count), .frame_rearm(frame_rearm),
    .snake_size(snake_size), .apple_pos(apple_pos),
    .body_addr(body_addr), .body_data(body_data),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
    .render_finish(render_finish), .busy(busy), .db_state(db_state)
  );

  always #5 clock = ~clock;

  // Body RAM with one-cycle synchronous read.
  logic [7:0] body_mem [0:63];
  always @(posedge clock) body_data <= body_mem[body_addr];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_wr_cyc = 0;
  bit mon_en = 1'b0;
  wr_t exp_q[$];
  wr_t wlog[$];
  logic [1:0] dut_fb [0:255];
  logic       m_tail_valid;
  logic [7:0] m_prev_tail;
  logic [7:0] pending_tail;

  function automatic wr_t wr(input logic [7:0] a, input logic [1:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    return w;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every frame-buffer write must be the next predicted write.
  always @(negedge clock) begin
    wr_t e;
    cyc++;
    if (mon_en && fb_we === 1'b1) begin
      wlog.push_back(wr(fb_addr, fb_data));
      dut_fb[fb_addr] = fb_data;
      last_wr_cyc = cyc;
      chk("we_while_busy", busy, 1);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL stray_write: got addr %0h data %0h, expected no write", fb_addr, fb_data);
      end else begin
        e = exp_q.pop_front();
        chk("fb_write", wr(fb_addr, fb_data), e);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic samp();
    @(negedge clock);
    #1;
  endtask

  // Predict the writes of a full pass from the snake/apple picture.
  task automatic build_pass(input int sz, input logic [7:0] ap);
    int s = (sz == 0) ? 1 : sz;
    if (m_tail_valid) exp_q.push_back(wr(m_prev_tail, E));
    exp_q.push_back(wr(body_mem[0], H));
    for (int i = 1; i < s; i++) exp_q.push_back(wr(body_mem[i], B));
    exp_q.push_back(wr(ap, A));
    pending_tail = body_mem[s-1];
  endtask

  task automatic push_clear();
    for (int i = 0; i < 256; i++) exp_q.push_back(wr(8'(i), E));
  endtask

  // render_count pulses spaced two cycles apart.
  task automatic run_pass(input int n);
    for (int i = 0; i < n; i++) begin
      render_count = 1'b1;
      tick();
      render_count = 1'b0;
      tick();
    end
  endtask

  task automatic wait_finish(input string nm);
    int n = 0;
    samp();
    while (render_finish !== 1'b1 && n < 20) begin
      samp();
      n++;
    end
    chk({nm, "_finish"}, render_finish, 1);
    chk({nm, "_finish_lat"}, cyc - last_wr_cyc, 1);
    chk({nm, "_all_written"}, exp_q.size(), 0);
  endtask

  task automatic rearm();
    frame_rearm = 1'b1;
    tick();
    frame_rearm = 1'b0;
    samp();
    chk("rearm_finish_low", render_finish, 0);
    chk("rearm_state", db_state, 2);
  endtask

  // Frame must show exactly the snake and apple, everything else EMPTY.
  task automatic frame_check(input string nm, input int sz, input logic [7:0] ap);
    logic [1:0] g [0:255];
    int mism = 0;
    int s = (sz == 0) ? 1 : sz;
    for (int c = 0; c < 256; c++) g[c] = E;
    for (int i = 1; i < s; i++) g[body_mem[i]] = B;
    g[body_mem[0]] = H;
    g[ap] = A;
    for (int c = 0; c < 256; c++) if (dut_fb[c] !== g[c]) mism++;
    chk(nm, mism, 0);
  endtask

  task automatic wait_clear_done(input string nm);
    int n = 0;
    while (db_state !== 3'd2 && n < 300) begin
      samp();
      n++;
    end
    chk({nm, "_ready"}, db_state, 2);
    chk({nm, "_all_written"}, exp_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    int nonempty;
    restart_n = 1'b0; render_clr = 1'b1; render_count = 1'b0; frame_rearm = 1'b0;
    snake_size = 6'd0; apple_pos = 8'h00;
    for (int i = 0; i < 64; i++) body_mem[i] = 8'h00;
    for (int c = 0; c < 256; c++) dut_fb[c] = A;
    m_tail_valid = 1'b0;
    m_prev_tail = 8'h00;

    // Reset state.
    repeat (3) samp();
    chk("rst_state", db_state, 0);
    chk("rst_we", fb_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_finish", render_finish, 0);
    chk("rst_body_addr", body_addr, 0);
    chk("rst_fb_addr", fb_addr, 0);

    // render_clr already high at release: full sweep.
    push_clear();
    mon_en = 1'b1;
    restart_n = 1'b1;
    nb = 0;
    for (int k = 0; k < 300; k++) begin
      samp();
      if (busy === 1'b1) nb++;
      else if (nb > 0) break;
    end
    chk("clear_busy_cycles", nb, 256);
    chk("clear_then_ready", db_state, 2);
    chk("clear_finish_low", render_finish, 0);
    chk("clear_all_written", exp_q.size(), 0);
    nonempty = 0;
    for (int c = 0; c < 256; c++) if (dut_fb[c] !== E) nonempty++;
    chk("frame_cleared", nonempty, 0);
    render_clr = 1'b0;

    // Pass 1: size 3, no previous tail.
    snake_size = 6'd3; apple_pos = 8'h9A;
    body_mem[0] = 8'h55; body_mem[1] = 8'h54; body_mem[2] = 8'h53;
    wlog.delete();
    build_pass(3, 8'h9A);
    run_pass(5);
    wait_finish("p1");
    chk("p1_nwrites", wlog.size(), 4);
    chk("p1_first", wlog[0], wr(8'h55, H));
    chk("p1_last", wlog[3], wr(8'h9A, A));
    frame_check("p1_frame", 3, 8'h9A);
    repeat (3) samp();
    chk("p1_finish_held", render_finish, 1);
    m_prev_tail = pending_tail; m_tail_valid = 1'b1;

    // Pass 2: snake moves, old tail 0x53 is erased first.
    rearm();
    body_mem[0] = 8'h56; body_mem[1] = 8'h55; body_mem[2] = 8'h54;
    wlog.delete();
    build_pass(3, 8'h9A);
    run_pass(5);
    wait_finish("p2");
    chk("p2_first", wlog[0], wr(8'h53, E));
    chk("p2_second", wlog[1], wr(8'h56, H));
    frame_check("p2_frame", 3, 8'h9A);
    m_prev_tail = pending_tail; m_tail_valid = 1'b1;

    // Pass 3: rearm while fetching the first body segment after HEAD.
    rearm();
    body_mem[0] = 8'h57; body_mem[1] = 8'h56; body_mem[2] = 8'h55;
    wlog.delete();
    build_pass(3, 8'h9A);
    run_pass(2);
    render_count = 1'b1;
    tick();
    render_count = 1'b0;
    exp_q.delete();
    chk("p3_partial_writes", wlog.size(), 2);
    chk("p3_partial_erase", wlog[0], wr(8'h54, E));
    frame_rearm = 1'b1;
    tick();
    frame_rearm = 1'b0;
    repeat (3) samp();
    chk("p3_abort_finish_low", render_finish, 0);
    chk("p3_abort_ready", db_state, 2);
    chk("p3_no_stray", wlog.size(), 2);
    wlog.delete();
    build_pass(3, 8'h9A);
    run_pass(5);
    wait_finish("p3");
    chk("p3_restart_first", wlog[0], wr(8'h54, E));
    chk("p3_restart_head", wlog[1], wr(8'h57, H));
    frame_check("p3_frame", 3, 8'h9A);
    m_prev_tail = pending_tail; m_tail_valid = 1'b1;

    // Pass 4: render_clr edge while drawing idx 0.
    rearm();
    body_mem[0] = 8'h58; body_mem[1] = 8'h57; body_mem[2] = 8'h56;
    wlog.delete();
    build_pass(3, 8'h9A);
    render_count = 1'b1;
    tick();
    render_count = 1'b0;
    tick();
    render_clr = 1'b1;
    samp();
    exp_q.delete();
    push_clear();
    m_tail_valid = 1'b0;
    chk("p4_draw_write", wlog[0], wr(8'h55, E));
    samp();
    chk("p4_clear_state", db_state, 1);
    wait_clear_done("p4_clear");
    render_clr = 1'b0;
    wlog.delete();
    build_pass(3, 8'h9A);
    run_pass(5);
    wait_finish("p5");
    chk("p5_nwrites", wlog.size(), 4);
    chk("p5_first", wlog[0], wr(8'h58, H));
    frame_check("p5_frame", 3, 8'h9A);
    m_prev_tail = pending_tail; m_tail_valid = 1'b1;

    // Pass 6: snake_size 0 clamps to 1; render_count in FETCH and DONE ignored.
    rearm();
    snake_size = 6'd0; apple_pos = 8'h12;
    body_mem[0] = 8'h77;
    wlog.delete();
    build_pass(0, 8'h12);
    render_count = 1'b1;
    tick();
    tick();
    render_count = 1'b0;
    tick();
    chk("p6_fetch_ignored_state", db_state, 2);
    run_pass(2);
    wait_finish("p6");
    render_count = 1'b1;
    tick();
    render_count = 1'b0;
    repeat (3) samp();
    chk("p6_done_held", render_finish, 1);
    chk("p6_nwrites", wlog.size(), 3);
    chk("p6_erase", wlog[0], wr(8'h56, E));
    chk("p6_head", wlog[1], wr(8'h77, H));
    chk("p6_apple", wlog[2], wr(8'h12, A));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
